// File: rtl/sequenciador_ula.sv
// Sequences one ULA operation per request: latches operands, waits the ULA latency,
// captures the result and strobes controle_memoria so the result becomes the last value.
module sequenciador_ula #(
  parameter int unsigned LARGURA     = 8,
  parameter int unsigned CICLOS_EXEC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iniciar,
  input  logic [2:0]         operacao,
  input  logic [LARGURA-1:0] operando_a,
  input  logic [LARGURA-1:0] operando_b,
  input  logic               usar_memoria,
  input  logic [LARGURA-1:0] valor_memoria,
  input  logic [LARGURA-1:0] resultado_ula,
  input  logic               erro_ula,
  output logic [LARGURA-1:0] ula_a,
  output logic [LARGURA-1:0] ula_b,
  output logic [2:0]         ula_op,
  output logic               executar,
  output logic               ocupado,
  output logic               pronto,
  output logic               erro,
  output logic [LARGURA-1:0] resultado
);

  typedef enum logic [1:0] {StOcioso, StExecuta, StGrava} estado_e;

  localparam logic [3:0] ContIni = 4'(CICLOS_EXEC - 1);

  estado_e              estado_q, estado_d;
  logic [3:0]           contador_q, contador_d;
  logic [LARGURA-1:0]   ula_a_q, ula_a_d;
  logic [LARGURA-1:0]   ula_b_q, ula_b_d;
  logic [2:0]           ula_op_q, ula_op_d;
  logic [LARGURA-1:0]   resultado_q, resultado_d;
  logic                 erro_q, erro_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q    <= StOcioso;
      contador_q  <= '0;
      ula_a_q     <= '0;
      ula_b_q     <= '0;
      ula_op_q    <= '0;
      resultado_q <= '0;
      erro_q      <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      contador_q  <= contador_d;
      ula_a_q     <= ula_a_d;
      ula_b_q     <= ula_b_d;
      ula_op_q    <= ula_op_d;
      resultado_q <= resultado_d;
      erro_q      <= erro_d;
    end
  end

  always_comb begin
    estado_d    = estado_q;
    contador_d  = contador_q;
    ula_a_d     = ula_a_q;
    ula_b_d     = ula_b_q;
    ula_op_d    = ula_op_q;
    resultado_d = resultado_q;
    erro_d      = erro_q;
    unique case (estado_q)
      StOcioso: begin
        if (iniciar) begin
          ula_op_d   = operacao;
          ula_a_d    = usar_memoria ? valor_memoria : operando_a;
          ula_b_d    = operando_b;
          contador_d = ContIni;
          estado_d   = StExecuta;
        end
      end
      StExecuta: begin
        if (contador_q != 4'd0) begin
          contador_d = contador_q - 4'd1;
        end else begin
          resultado_d = resultado_ula;
          erro_d      = erro_ula;
          estado_d    = StGrava;
        end
      end
      StGrava: estado_d = StOcioso;
      default: estado_d = StOcioso;
    endcase
  end

  // Strobes come only from registered state/flags so they are glitch-free.
  assign ocupado   = (estado_q != StOcioso);
  assign pronto    = (estado_q == StGrava);
  assign executar  = pronto && (ula_op_q != 3'b000) && !erro_q;
  assign ula_a     = ula_a_q;
  assign ula_b     = ula_b_q;
  assign ula_op    = ula_op_q;
  assign resultado = resultado_q;
  assign erro      = erro_q;

endmodule

// File: tb/tb_sequenciador_ula.sv
// Randomized bench for sequenciador_ula with a stub adder ULA and a stub memory register;
// expectations come from a transaction-level model of each operation.
module tb_sequenciador_ula;

  localparam int unsigned W = 8;
  localparam int unsigned C = 2;

  logic         clk;
  logic         rst;
  logic         iniciar;
  logic [2:0]   operacao;
  logic [W-1:0] operando_a;
  logic [W-1:0] operando_b;
  logic         usar_memoria;
  logic [W-1:0] valor_memoria;
  logic [W-1:0] resultado_ula;
  logic         erro_ula;
  logic [W-1:0] ula_a;
  logic [W-1:0] ula_b;
  logic [2:0]   ula_op;
  logic         executar;
  logic         ocupado;
  logic         pronto;
  logic         erro;
  logic [W-1:0] resultado;

  int n_chk;
  int n_err;
  logic [W-1:0] mem_model;

  sequenciador_ula #(
    .LARGURA    (W),
    .CICLOS_EXEC(C)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .iniciar      (iniciar),
    .operacao     (operacao),
    .operando_a   (operando_a),
    .operando_b   (operando_b),
    .usar_memoria (usar_memoria),
    .valor_memoria(valor_memoria),
    .resultado_ula(resultado_ula),
    .erro_ula     (erro_ula),
    .ula_a        (ula_a),
    .ula_b        (ula_b),
    .ula_op       (ula_op),
    .executar     (executar),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .erro         (erro),
    .resultado    (resultado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ULA: adder, with a divide-by-zero style error on opcode 100 and B == 0.
  assign resultado_ula = ula_a + ula_b;
  assign erro_ula      = (ula_op == 3'b100) && (ula_b == '0);

  // Stub controle_memoria: stores the result on executar.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valor_memoria <= '0;
    else if (executar) valor_memoria <= resultado;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outs();
    check_eq("idle_pronto", 32'(pronto), 32'd0);
    check_eq("idle_executar", 32'(executar), 32'd0);
    check_eq("idle_ocupado", 32'(ocupado), 32'd0);
  endtask

  task automatic idle(input int n);
    iniciar = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_idle_outs();
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic usar, input logic hold, input logic spur);
    logic [W-1:0] ea, er;
    logic         ee, ex;
    ea = usar ? mem_model : a;
    er = ea + b;
    ee = (op == 3'b100) && (b == '0);
    ex = (op != 3'b000) && !ee;
    operacao     = op;
    operando_a   = a;
    operando_b   = b;
    usar_memoria = usar;
    iniciar      = 1'b1;
    @(negedge clk);
    iniciar      = hold | spur;
    operacao     = 3'($urandom);
    operando_a   = W'($urandom);
    operando_b   = W'($urandom);
    usar_memoria = 1'($urandom);
    for (int k = 0; k < int'(C); k++) begin
      check_eq("exec_ocupado", 32'(ocupado), 32'd1);
      check_eq("exec_pronto", 32'(pronto), 32'd0);
      check_eq("exec_executar", 32'(executar), 32'd0);
      check_eq("ula_a", 32'(ula_a), 32'(ea));
      check_eq("ula_b", 32'(ula_b), 32'(b));
      check_eq("ula_op", 32'(ula_op), 32'(op));
      @(negedge clk);
      if (!hold) iniciar = 1'b0;
    end
    check_eq("grava_pronto", 32'(pronto), 32'd1);
    check_eq("grava_executar", 32'(executar), 32'(ex));
    check_eq("grava_ocupado", 32'(ocupado), 32'd1);
    check_eq("resultado", 32'(resultado), 32'(er));
    check_eq("erro", 32'(erro), 32'(ee));
    if (ex) mem_model = er;
    @(negedge clk);
    check_idle_outs();
    check_eq("hold_resultado", 32'(resultado), 32'(er));
    check_eq("hold_ula_a", 32'(ula_a), 32'(ea));
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    mem_model    = '0;
    rst          = 1'b0;
    iniciar      = 1'b0;
    operacao     = '0;
    operando_a   = '0;
    operando_b   = '0;
    usar_memoria = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ula_a", 32'(ula_a), 32'd0);
    check_eq("rst_ula_b", 32'(ula_b), 32'd0);
    check_eq("rst_ula_op", 32'(ula_op), 32'd0);
    check_eq("rst_resultado", 32'(resultado), 32'd0);
    check_eq("rst_erro", 32'(erro), 32'd0);
    check_idle_outs();
    rst = 1'b1;
    @(negedge clk);

    // Basic timing, then chaining with held iniciar and memory operand.
    run_op(3'b001, 8'd5, 8'd3, 1'b0, 1'b1, 1'b0);
    run_op(3'b001, 8'd99, 8'd2, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Opcode 000: completes but is not stored.
    run_op(3'b000, 8'd7, 8'd1, 1'b0, 1'b0, 1'b0);
    check_eq("mem_after_op0", 32'(valor_memoria), 32'd10);
    // Ignored request while busy.
    run_op(3'b010, 8'd20, 8'd22, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Error capture, then cleared by an error-free operation.
    run_op(3'b100, 8'd9, 8'd0, 1'b0, 1'b0, 1'b0);
    run_op(3'b011, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      run_op(3'($urandom), W'($urandom), rb, 1'($urandom),
             (i != 39) && ($urandom_range(0, 1) == 1), 1'($urandom));
    end
    idle(1);

    // Asynchronous reset in the middle of EXECUTA.
    operacao     = 3'b001;
    operando_a   = 8'd40;
    operando_b   = 8'd2;
    usar_memoria = 1'b0;
    iniciar      = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    check_eq("pre_rst_ocupado", 32'(ocupado), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_ula_a", 32'(ula_a), 32'd0);
    check_eq("arst_ula_b", 32'(ula_b), 32'd0);
    check_eq("arst_ula_op", 32'(ula_op), 32'd0);
    check_eq("arst_resultado", 32'(resultado), 32'd0);
    check_eq("arst_erro", 32'(erro), 32'd0);
    check_idle_outs();
    mem_model = '0;
    @(negedge clk);
    rst = 1'b1;
    idle(5);
    run_op(3'b001, 8'd12, 8'd30, 1'b1, 1'b0, 1'b0);
    run_op(3'b001, 8'd0, 8'd4, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sequenciador_ula.md
Name: sequenciador_ula

Overview:
FSM that sequences one ULA operation per request. On a start request it latches the opcode and operands, optionally taking operand A from the memory register. It drives the ULA for a fixed number of cycles, then captures the result and error flag. It finally issues a one-cycle `executar` pulse toward controle_memoria so the result is stored as the last value. It sits between the input/keypad logic and the ULA/controle_memoria pair.

Parameters:
- LARGURA, 8, datapath width of operands and result.
- CICLOS_EXEC, 2, ULA latency in clock cycles (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset: asynchronous, active-low.
- iniciar  input  1  start request, sampled only in OCIOSO (level; held high gives back-to-back operations).
- operacao  input  3  opcode, sampled at the accept edge.
- operando_a  input  LARGURA  operand A.
- operando_b  input  LARGURA  operand B.
- usar_memoria  input  1  when 1 at the accept edge, A is taken from valor_memoria instead of operando_a.
- valor_memoria  input  LARGURA  current memory register value from controle_memoria.
- resultado_ula  input  LARGURA  ULA result.
- erro_ula  input  1  ULA error flag (e.g. divide by zero).
- ula_a  output  LARGURA  registered operand A to the ULA.
- ula_b  output  LARGURA  registered operand B to the ULA.
- ula_op  output  3  registered opcode to the ULA.
- executar  output  1  one-cycle store strobe to controle_memoria.
- ocupado  output  1  high whenever the state is not OCIOSO.
- pronto  output  1  one-cycle completion pulse.
- erro  output  1  captured error flag of the last operation.
- resultado  output  LARGURA  captured result of the last operation.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state = OCIOSO, counter = 0.
  - All outputs = 0: ula_a, ula_b, ula_op, resultado, erro, executar, pronto, ocupado.
  - Reset mid-operation aborts it: no executar or pronto is produced afterward.
- States: OCIOSO, EXECUTA, GRAVA.
- OCIOSO:
  - On an edge with iniciar=1 (the accept edge E0):
    - ula_op <= operacao.
    - ula_a <= (usar_memoria ? valor_memoria : operando_a).
    - ula_b <= operando_b.
    - counter <= CICLOS_EXEC-1; state <= EXECUTA.
  - Otherwise remain in OCIOSO. ula_* hold their last values.
- EXECUTA:
  - ula_* are held stable.
  - While counter != 0: counter decrements each edge.
  - On the edge where counter == 0 (edge E0+CICLOS_EXEC):
    - resultado <= resultado_ula, erro <= erro_ula.
    - state <= GRAVA.
- GRAVA (exactly one cycle, between edges E0+C and E0+C+1):
  - pronto = 1.
  - executar = 1 only if ula_op != 000 and erro = 0.
  - Next edge: state <= OCIOSO.
- executar and pronto are decoded from the state and registered flags only (glitch-free, no combinational path from inputs).
- Latency:
  - Accept to pronto: CICLOS_EXEC edges.
  - Earliest next accept: edge E0+CICLOS_EXEC+2.
  - Back-to-back period: CICLOS_EXEC+2 cycles.
- Chaining: controle_memoria loads at edge E0+C+1, so a following accept with usar_memoria=1 always sees the new value. No bypass is needed.
- iniciar while ocupado=1 is ignored, not queued.
- Operand or opcode input changes after E0 have no effect on the current operation.
- resultado and erro hold until the next capture. They are not cleared on accept.
- ocupado = 1 in EXECUTA and GRAVA, 0 in OCIOSO.
- The width of resultado equals LARGURA; no extension or truncation is performed here.

Test Plan:
- Basic timing: C=2, stub ULA = a+b, iniciar pulse with op=001, A=5, B=3.
  - Expect ula_a=5 and ula_b=3 after E0.
  - Expect resultado=8 and pronto=executar=1 for exactly one cycle starting 2 edges after E0.
  - Expect ocupado high for 3 cycles.
- Opcode 000: op=000, A=7, B=1 → pronto pulses, resultado=8, executar stays 0.
- Memory chaining: first op A=5, B=3 (result 8 stored by controle_memoria), then held iniciar with usar_memoria=1, B=2 → ula_a=8, second resultado=10, second accept exactly 4 edges after the first.
- Busy/error:
  - iniciar pulse during EXECUTA → ignored; exactly one pronto observed.
  - erro_ula=1 at the capture edge → erro=1, pronto=1, executar=0.
  - erro is cleared by the next error-free operation.
- Reset mid-operation: rst=0 asynchronously during EXECUTA → all outputs 0 immediately. After release, no pronto/executar until a new iniciar; the next operation completes normally.
